lfsr_test_ctrl: RTL and testbench

//  Burst sequencer for the PRBS stimulus generator (22-bit LFSR) in the DSP modem test path.

---
 rtl/lfsr_test_ctrl_if.sv | 23 ++
 rtl/lfsr_test_ctrl.sv | 122 ++++++++++++
 tb/tb_lfsr_test_ctrl.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/lfsr_test_ctrl_if.sv
// Host-side control bundle for the PRBS burst sequencer: burst request in,
// status and counters out.
interface lfsr_test_ctrl_if #(
  parameter int SYM_CNT_W = 16
);
  logic                 start;
  logic                 abort;
  logic [SYM_CNT_W-1:0] num_symbols;
  logic                 busy;
  logic                 done;
  logic [SYM_CNT_W-1:0] sym_count;
  logic [7:0]           rollover_count;

  modport master (
    output start, abort, num_symbols,
    input  busy, done, sym_count, rollover_count
  );

  modport slave (
    input  start, abort, num_symbols,
    output busy, done, sym_count, rollover_count
  );
endinterface

// File: rtl/lfsr_test_ctrl.sv
// Burst sequencer for the 22-bit PRBS LFSR: parks/reseeds the LFSR between
// bursts, generates sample/symbol strobes for a programmed number of symbols,
// counts LFSR rollovers and pulses done on normal completion.
module lfsr_test_ctrl #(
  parameter int CLK_PER_SAM = 4,
  parameter int SAM_PER_SYM = 4,
  parameter int SYM_CNT_W   = 16,
  parameter int SEED_CYCLES = 2
) (
  input  logic            clk,
  input  logic            reset,
  lfsr_test_ctrl_if.slave ctl,
  input  logic            rollover,
  output logic            lfsr_reset,
  output logic            sam_clk_ena,
  output logic            sym_clk_ena
);

  // Counter widths; a degenerate ratio of 1 still gets a 1-bit counter.
  localparam int DIV_W  = (CLK_PER_SAM > 1) ? $clog2(CLK_PER_SAM) : 1;
  localparam int SAM_W  = (SAM_PER_SYM > 1) ? $clog2(SAM_PER_SYM) : 1;
  localparam int SEED_W = (SEED_CYCLES > 1) ? $clog2(SEED_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, SEED, RUN, DONE} state_t;

  state_t               state, state_nxt;
  logic [DIV_W-1:0]     div_cnt;
  logic [SAM_W-1:0]     sam_cnt;
  logic [SEED_W-1:0]    seed_cnt;
  logic [SYM_CNT_W-1:0] n_lat;
  logic [SYM_CNT_W-1:0] sym_cnt;
  logic [7:0]           roll_cnt;
  logic                 rollover_d;

  logic accept, seed_end, div_end, sam_end, last_sym;
  logic sam_hit, sym_hit, roll_rise;

  // Start is only honoured in IDLE with a non-empty burst.
  assign accept    = (state == IDLE) && ctl.start && (ctl.num_symbols != '0);
  assign seed_end  = (seed_cnt == SEED_W'(SEED_CYCLES - 1));
  assign div_end   = (div_cnt == DIV_W'(CLK_PER_SAM - 1));
  assign sam_end   = (sam_cnt == SAM_W'(SAM_PER_SYM - 1));
  assign last_sym  = ((sym_cnt + SYM_CNT_W'(1)) == n_lat);
  // Strobes decode purely from registered state so no input reaches them.
  assign sam_hit   = (state == RUN) && div_end;
  assign sym_hit   = sam_hit && sam_end;
  // Seed value held high through SEED leaves rollover_d high, so no count on RUN entry.
  assign roll_rise = (state == RUN) && rollover && !rollover_d;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic; abort takes priority over completion.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = SEED;
      SEED: begin
        if (ctl.abort)     state_nxt = IDLE;
        else if (seed_end) state_nxt = RUN;
      end
      RUN: begin
        if (ctl.abort)               state_nxt = IDLE;
        else if (sym_hit && last_sym) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode from state and registered counters.
  always_comb begin
    lfsr_reset  = (state != RUN);
    sam_clk_ena = sam_hit;
    sym_clk_ena = sym_hit;
    ctl.busy    = (state == SEED) || (state == RUN);
    ctl.done    = (state == DONE);
  end

  // SEED dwell counter and the sample/symbol dividers, all parked outside RUN.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seed_cnt <= '0;
      div_cnt  <= '0;
      sam_cnt  <= '0;
    end else begin
      seed_cnt <= (state == SEED) ? seed_cnt + SEED_W'(1) : '0;
      if (state != RUN)  div_cnt <= '0;
      else if (div_end)  div_cnt <= '0;
      else               div_cnt <= div_cnt + DIV_W'(1);
      if (state != RUN)  sam_cnt <= '0;
      else if (sam_hit)  sam_cnt <= sam_end ? '0 : sam_cnt + SAM_W'(1);
    end
  end

  // Burst length latch, symbol and rollover counters; cleared on accepted start.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      n_lat      <= '0;
      sym_cnt    <= '0;
      roll_cnt   <= '0;
      rollover_d <= 1'b0;
    end else begin
      rollover_d <= rollover;
      if (accept) begin
        n_lat    <= ctl.num_symbols;
        sym_cnt  <= '0;
        roll_cnt <= '0;
      end else begin
        if (sym_hit) sym_cnt <= sym_cnt + SYM_CNT_W'(1);
        if (roll_rise && (roll_cnt != 8'hFF)) roll_cnt <= roll_cnt + 8'd1;
      end
    end
  end

  assign ctl.sym_count      = sym_cnt;
  assign ctl.rollover_count = roll_cnt;

endmodule

// File: tb/tb_lfsr_test_ctrl.sv
// Scoreboard bench for lfsr_test_ctrl: two instances (default ratios and a
// fast 2:1 / 1:1 configuration). Each burst pushes its expected strobe/done
// events, computed from burst length and rollover pattern, into a queue; a
// negedge monitor pops and compares whenever a DUT shows a strobe or done.
module tb_lfsr_test_ctrl;
  localparam int SEEDC = 2;

  typedef struct {
    int cyc;
    bit sam;
    bit sym;
    bit done;
    int scnt;
    int rcnt;
  } ev_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [1:0]  st, ab, roll;
  logic [15:0] nsym [2];
  logic        lrst_v [2];
  logic        sam_v  [2];
  logic        sym_v  [2];
  logic        busy_v [2];
  logic        done_v [2];
  logic [15:0] scnt_v [2];
  logic [7:0]  rcnt_v [2];

  lfsr_test_ctrl_if #(.SYM_CNT_W(16)) ifa ();
  lfsr_test_ctrl_if #(.SYM_CNT_W(16)) ifb ();

  assign ifa.start = st[0];
  assign ifa.abort = ab[0];
  assign ifa.num_symbols = nsym[0];
  assign ifb.start = st[1];
  assign ifb.abort = ab[1];
  assign ifb.num_symbols = nsym[1];
  assign busy_v[0] = ifa.busy;
  assign done_v[0] = ifa.done;
  assign scnt_v[0] = ifa.sym_count;
  assign rcnt_v[0] = ifa.rollover_count;
  assign busy_v[1] = ifb.busy;
  assign done_v[1] = ifb.done;
  assign scnt_v[1] = ifb.sym_count;
  assign rcnt_v[1] = ifb.rollover_count;

  lfsr_test_ctrl dut_a (
    .clk(clk), .reset(reset), .ctl(ifa), .rollover(roll[0]),
    .lfsr_reset(lrst_v[0]), .sam_clk_ena(sam_v[0]), .sym_clk_ena(sym_v[0])
  );

  lfsr_test_ctrl #(.CLK_PER_SAM(2), .SAM_PER_SYM(1), .SYM_CNT_W(16), .SEED_CYCLES(SEEDC)) dut_b (
    .clk(clk), .reset(reset), .ctl(ifb), .rollover(roll[1]),
    .lfsr_reset(lrst_v[1]), .sam_clk_ena(sam_v[1]), .sym_clk_ena(sym_v[1])
  );

  int  errors = 0;
  int  checks = 0;
  ev_t qa[$];
  ev_t qb[$];
  bit  rp[$];

  function automatic int cps(input int d);
    return (d == 0) ? 4 : 2;
  endfunction

  function automatic int sps(input int d);
    return (d == 0) ? 4 : 1;
  endfunction

  function automatic bit rb(input int o);
    return (o >= 0 && o < rp.size()) ? rp[o] : 1'b0;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic push_ev(input int d, input ev_t e);
    if (d == 0) qa.push_back(e);
    else        qb.push_back(e);
  endtask

  // Monitor: any strobe or done must match the head of that DUT's queue.
  task automatic mon(input int d);
    ev_t e;
    bit  empty;
    if (sam_v[d] !== 1'b1 && sym_v[d] !== 1'b1 && done_v[d] !== 1'b1) return;
    checks++;
    empty = (d == 0) ? (qa.size() == 0) : (qb.size() == 0);
    if (empty) begin
      errors++;
      $display("FAIL unexpected_out dut%0d cyc %0d: got sam=%b sym=%b done=%b, expected none",
               d, cyc, sam_v[d], sym_v[d], done_v[d]);
      return;
    end
    if (d == 0) e = qa.pop_front();
    else        e = qb.pop_front();
    if (e.cyc != cyc || sam_v[d] !== e.sam || sym_v[d] !== e.sym || done_v[d] !== e.done ||
        (e.done && (32'(scnt_v[d]) != e.scnt || 32'(rcnt_v[d]) != e.rcnt))) begin
      errors++;
      $display("FAIL event dut%0d: got cyc=%0d sam=%b sym=%b done=%b scnt=%0d rcnt=%0d, expected cyc=%0d sam=%b sym=%b done=%b scnt=%0d rcnt=%0d",
               d, cyc, sam_v[d], sym_v[d], done_v[d], scnt_v[d], rcnt_v[d],
               e.cyc, e.sam, e.sym, e.done, e.scnt, e.rcnt);
    end
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) mon(d);
  end

  // One burst of n symbols on DUT d, optional abort on RUN cycle abort_at,
  // rollover driven from rp[] indexed by cycle offset from the start cycle.
  task automatic run_burst(input int d, input int n, input int abort_at);
    int  s, per_sym, len, lr, edges, last;
    ev_t e;
    per_sym = cps(d) * sps(d);
    len     = n * per_sym;
    lr      = (abort_at > 0) ? abort_at : len;
    if (abort_at > 0) begin
      while (rp.size() <= SEEDC + abort_at) rp.push_back(1'b0);
      rp[SEEDC + abort_at] = 1'b0;
    end
    @(posedge clk); #1;
    s = cyc;
    for (int r = 1; r <= lr; r++) begin
      if (r % cps(d) == 0) begin
        e.cyc = s + SEEDC + r; e.sam = 1'b1; e.sym = (r % per_sym == 0);
        e.done = 1'b0; e.scnt = 0; e.rcnt = 0;
        push_ev(d, e);
      end
    end
    edges = 0;
    for (int o = SEEDC + 1; o <= SEEDC + lr; o++)
      if (rb(o) && !rb(o - 1)) edges++;
    if (edges > 255) edges = 255;
    if (abort_at == 0) begin
      e.cyc = s + SEEDC + len + 1; e.sam = 1'b0; e.sym = 1'b0;
      e.done = 1'b1; e.scnt = n; e.rcnt = edges;
      push_ev(d, e);
    end
    last = SEEDC + lr + 1;
    for (int o = 0; o <= last; o++) begin
      if (o > 0) begin
        chk("busy", 32'(busy_v[d]), 32'(o <= SEEDC + lr));
        chk("lfsr_reset", 32'(lrst_v[d]), 32'(!(o > SEEDC && o <= SEEDC + lr)));
      end
      st[d]   = (o == 0) || (o == SEEDC + 3 && lr >= 3) || (abort_at == 0 && o == last);
      nsym[d] = (o == 0) ? 16'(n) : 16'($urandom_range(1, 65535));
      ab[d]   = (abort_at > 0 && o == SEEDC + abort_at);
      roll[d] = rb(o);
      @(posedge clk); #1;
    end
    st[d] = 1'b0; ab[d] = 1'b0; roll[d] = 1'b0;
    chk("busy_after", 32'(busy_v[d]), 0);
    chk("lfsr_reset_after", 32'(lrst_v[d]), 1);
    chk("rollover_count", 32'(rcnt_v[d]), 32'(edges));
    if (!(abort_at > 0 && abort_at % per_sym == 0))
      chk("sym_count", 32'(scnt_v[d]), 32'((abort_at > 0) ? abort_at / per_sym : n));
    repeat (3) begin @(posedge clk); #1; end
    chk("queue_empty", 32'((d == 0) ? qa.size() : qb.size()), 0);
  endtask

  initial begin
    int d, n, len, ab_at;
    reset = 1'b1; st = '0; ab = '0; roll = '0; nsym[0] = '0; nsym[1] = '0;
    repeat (3) begin @(posedge clk); #1; end
    for (int i = 0; i < 2; i++) begin
      chk("rst_lfsr_reset", 32'(lrst_v[i]), 1);
      chk("rst_sam", 32'(sam_v[i]), 0);
      chk("rst_sym", 32'(sym_v[i]), 0);
      chk("rst_busy", 32'(busy_v[i]), 0);
      chk("rst_done", 32'(done_v[i]), 0);
      chk("rst_sym_count", 32'(scnt_v[i]), 0);
      chk("rst_rollover_count", 32'(rcnt_v[i]), 0);
    end
    reset = 1'b0;

    // N=3, rollover high through SEED and at RUN cycles 10 and 30.
    rp.delete();
    for (int o = 0; o < 60; o++) rp.push_back(o <= SEEDC || o == SEEDC + 10 || o == SEEDC + 30);
    run_burst(0, 3, 0);

    // Abort mid-burst, then abort coinciding with the final symbol strobe.
    rp.delete();
    run_burst(0, 3, 20);
    run_burst(0, 2, 32);

    // 300 rollover pulses saturate the counter.
    rp.delete();
    for (int o = 0; o < SEEDC + 650; o++) rp.push_back(o > SEEDC && o <= SEEDC + 599 && ((o - SEEDC) % 2 == 1));
    run_burst(0, 40, 0);

    // Async reset during RUN returns to reset values and stays idle.
    @(posedge clk); #1; st[0] = 1'b1; nsym[0] = 16'd3;
    @(posedge clk); #1; st[0] = 1'b0;
    repeat (SEEDC + 1) begin @(posedge clk); #1; end
    chk("busy_pre_reset", 32'(busy_v[0]), 1);
    #2 reset = 1'b1;
    #1;
    chk("async_busy", 32'(busy_v[0]), 0);
    chk("async_lfsr_reset", 32'(lrst_v[0]), 1);
    chk("async_sym_count", 32'(scnt_v[0]), 0);
    chk("async_rollover_count", 32'(rcnt_v[0]), 0);
    @(posedge clk); #1; reset = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    chk("idle_after_reset", 32'(busy_v[0]), 0);

    // Start with zero symbols is ignored.
    @(posedge clk); #1; st[0] = 1'b1; nsym[0] = 16'd0;
    @(posedge clk); #1; st[0] = 1'b0;
    chk("zero_n_busy", 32'(busy_v[0]), 0);
    chk("zero_n_lfsr_reset", 32'(lrst_v[0]), 1);
    repeat (3) begin @(posedge clk); #1; end
    chk("zero_n_busy_later", 32'(busy_v[0]), 0);

    // Fast configuration, N=5.
    rp.delete();
    run_burst(1, 5, 0);

    // Randomized bursts on both configurations.
    for (int k = 0; k < 10; k++) begin
      d     = int'($urandom_range(0, 1));
      n     = (d == 1) ? int'($urandom_range(1, 8)) : int'($urandom_range(1, 3));
      len   = n * cps(d) * sps(d);
      ab_at = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, len)) : 0;
      rp.delete();
      for (int o = 0; o < SEEDC + len + 3; o++) rp.push_back($urandom_range(0, 9) < 3);
      run_burst(d, n, ab_at);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
